// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: free-running h/v counters feeding one
// registered output stage, so sync, data-enable, coordinates and strobes describe the same pixel.
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   CNT_W    = 11
) (
  input  logic             pixel_clk,
  input  logic             rst,
  input  logic             pix_en,
  output logic             vga_h_sync,
  output logic             vga_v_sync,
  output logic             inDisplayArea,
  output logic [CNT_W-1:0] CounterX,
  output logic [CNT_W-1:0] CounterY,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // One extra bit keeps the sync-window sums from wrapping for any legal CNT_W.
  localparam logic [CNT_W:0] C_H_LAST  = (CNT_W+1)'(H_TOTAL - 1);
  localparam logic [CNT_W:0] C_H_ACT   = (CNT_W+1)'(H_ACTIVE);
  localparam logic [CNT_W:0] C_HS_BEG  = (CNT_W+1)'(H_ACTIVE + H_FP);
  localparam logic [CNT_W:0] C_HS_END  = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W:0] C_V_LAST  = (CNT_W+1)'(V_TOTAL - 1);
  localparam logic [CNT_W:0] C_V_ACT   = (CNT_W+1)'(V_ACTIVE);
  localparam logic [CNT_W:0] C_VS_BEG  = (CNT_W+1)'(V_ACTIVE + V_FP);
  localparam logic [CNT_W:0] C_VS_END  = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] C_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);

  generate
    if ((H_TOTAL > (2 ** CNT_W)) || (V_TOTAL > (2 ** CNT_W))) begin : g_cnt_w_too_small
      $error("vga_timing_gen: CNT_W cannot hold H_TOTAL-1 / V_TOTAL-1");
    end
  endgenerate

  logic [CNT_W-1:0] r_h_cnt;
  logic [CNT_W-1:0] r_v_cnt;
  logic [CNT_W:0]   w_h_ext;
  logic [CNT_W:0]   w_v_ext;
  logic [CNT_W-1:0] w_h_next;
  logic [CNT_W-1:0] w_v_next;
  logic             w_h_last;
  logic             w_v_last;
  logic             w_de;
  logic             w_hs_act;
  logic             w_vs_act;
  logic             w_line;
  logic             w_frame;

  // Next-count and per-pixel decode, all derived from the pre-increment counters.
  always_comb begin
    w_h_ext  = {1'b0, r_h_cnt};
    w_v_ext  = {1'b0, r_v_cnt};
    w_h_last = (w_h_ext == C_H_LAST);
    w_v_last = (w_v_ext == C_V_LAST);
    w_h_next = r_h_cnt;
    w_v_next = r_v_cnt;
    if (w_h_last) begin
      w_h_next = C_ZERO;
      if (w_v_last) begin
        w_v_next = C_ZERO;
      end else begin
        w_v_next = r_v_cnt + C_ONE;
      end
    end else begin
      w_h_next = r_h_cnt + C_ONE;
      w_v_next = r_v_cnt;
    end
    w_de     = (w_h_ext < C_H_ACT) && (w_v_ext < C_V_ACT);
    w_hs_act = (w_h_ext >= C_HS_BEG) && (w_h_ext < C_HS_END);
    w_vs_act = (w_v_ext >= C_VS_BEG) && (w_v_ext < C_VS_END);
    w_line   = (r_h_cnt == C_ZERO);
    w_frame  = w_line && (r_v_cnt == C_ZERO);
  end

  // Raster counters advance only on enabled edges.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      r_h_cnt <= C_ZERO;
      r_v_cnt <= C_ZERO;
    end else if (pix_en) begin
      r_h_cnt <= w_h_next;
      r_v_cnt <= w_v_next;
    end
  end

  // Output stage: everything lags the counters by exactly one enabled edge and holds on stalls.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      CounterX      <= C_ZERO;
      CounterY      <= C_ZERO;
      inDisplayArea <= 1'b0;
      vga_h_sync    <= ~HS_POL;
      vga_v_sync    <= ~VS_POL;
      line_start    <= 1'b0;
      frame_start   <= 1'b0;
    end else if (pix_en) begin
      CounterX      <= r_h_cnt;
      CounterY      <= r_v_cnt;
      inDisplayArea <= w_de;
      vga_h_sync    <= w_hs_act ? HS_POL : ~HS_POL;
      vga_v_sync    <= w_vs_act ? VS_POL : ~VS_POL;
      line_start    <= w_line;
      frame_start   <= w_frame;
    end
  end

endmodule
